fg_framebuffer_writer: RTL and testbench
========================================

Name: fg_framebuffer_writer

Overview:
Write side of the foreground frame buffer. Accepts the captured foreground video stream as pixel data plus source coordinates, drops out-of-frame pixels, and computes a linear SRAM address. Buffers each pixel/address pair in a small FIFO and issues write requests to the SRAM arbiter over a req/ack handshake. The display-side foreground scaler later reads these locations back by fg_pixel_x/fg_pixel_y.

Parameters:
RESOLUTION_X, 800, foreground frame width in pixels
RESOLUTION_Y, 600, foreground frame height in pixels
PRECISION, 11, width of the unsigned capture coordinates
PIXEL_BITS, 12, pixel data width (RGB444)
ADDR_BITS, 19, SRAM word address width; must satisfy 2^ADDR_BITS >= RESOLUTION_X*RESOLUTION_Y
FIFO_DEPTH_LOG2, 4, FIFO depth = 16 entries

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
frame_start  in  1  one-cycle pulse at the start of each captured frame
capture_valid  in  1  capture_x/y/pixel valid this cycle; no backpressure toward the source
capture_x  in  PRECISION  source column
capture_y  in  PRECISION  source row
capture_pixel  in  PIXEL_BITS  pixel data
wr_req  out  1  write request to the SRAM arbiter
wr_addr  out  ADDR_BITS  write address; stable while wr_req=1
wr_data  out  PIXEL_BITS  write data; stable while wr_req=1
wr_ack  in  1  arbiter accepts the current request on this edge
fifo_level  out  FIFO_DEPTH_LOG2+1  current FIFO occupancy, 0..16
overflow  out  1  sticky flag: a pixel was dropped because the FIFO was full
dropped_count  out  16  pixels dropped for overflow since the last frame_start; saturates at 16'hFFFF

Behaviour:
- Reset (async, rst=1): wr_req=0, wr_addr=0, wr_data=0, fifo_level=0, overflow=0, dropped_count=0. The stage-1 valid bit is cleared and FIFO pointers go to zero. Reset during an outstanding request drops wr_req immediately, and all pending entries are lost.
- Stage 1 (edge E0): register capture_valid && (capture_x < RESOLUTION_X) && (capture_y < RESOLUTION_Y), together with the pixel. Register addr = capture_y*RESOLUTION_X + capture_x, computed at full width then truncated to ADDR_BITS.
- Out-of-range pixels are discarded silently: no FIFO push, and they do not count toward overflow.
- Stage 2 (edge E1): if the stage-1 entry is valid, push it into the FIFO. Push succeeds if level < 16, or if level == 16 and a pop occurs on the same edge.
- Failed push: overflow <= 1 and dropped_count increments (saturating).
- Output: wr_req = FIFO non-empty. wr_addr/wr_data = head entry. Total latency from capture edge E0 into an empty FIFO: wr_req high in the cycle after E1 (2 cycles).
- Handshake: a pop occurs on a rising edge where wr_req && wr_ack. wr_ack while wr_req=0 is ignored. Back-to-back acks drain one entry per cycle. The head stays stable until acked.
- Simultaneous push and pop: fifo_level is unchanged, including at level 16.
- frame_start:
  - clears overflow and dropped_count on that edge. If an overflow drop happens on the same edge, the result is overflow=1, dropped_count=1.
  - does not flush the FIFO or the pipeline; pending writes from the previous frame still complete.
- Pointers wrap modulo 16. fifo_level is an explicit counter.

Decomposition:
- Shared package fg_pkg: RESOLUTION_X/Y, PRECISION, PIXEL_BITS, ADDR_BITS, and the pixel typedef, shared with the display-side scaler and the SRAM arbiter.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH_LOG2; push/pop/full/empty/level). Instantiated with WIDTH = ADDR_BITS + PIXEL_BITS.

Test Plan:
1. Single pixel, idle FIFO: valid at x=5, y=2, pixel=12'hABC, wr_ack tied 1 -> wr_req high exactly 2 cycles after capture, wr_addr=1605, wr_data=ABC, one write only.
2. Out of range: x=800, y=0, then x=0, y=600, then x=799, y=599 -> only the last is written, wr_addr=479999; overflow stays 0.
3. Backpressure/overflow: wr_ack=0, 20 consecutive valid pixels -> fifo_level=16, overflow=1, dropped_count=4. Then wr_ack=1 -> 16 writes in capture order, level returns to 0.
4. Full with simultaneous push/pop: level 16, one valid pixel and wr_ack=1 on the same edge -> level stays 16, dropped_count unchanged.
5. frame_start with pending data: level 5, overflow=1, pulse frame_start -> overflow=0, dropped_count=0, all 5 entries still written.
6. Async reset mid-request: level 3, wr_req=1, assert rst between edges -> wr_req=0 and level=0 immediately. After release, no stale writes are issued.

Source files
------------

// File: rtl/fg_pkg.sv
// Shared foreground frame-buffer definitions, common to the capture writer,
// the display-side scaler and the SRAM arbiter.
package fg_pkg;

    localparam int RESOLUTION_X    = 800;
    localparam int RESOLUTION_Y    = 600;
    localparam int PRECISION       = 11;
    localparam int PIXEL_BITS      = 12;
    localparam int ADDR_BITS       = 19;
    localparam int FIFO_DEPTH_LOG2 = 4;

    // y*RESOLUTION_X + x needs this many bits before truncation to ADDR_BITS
    localparam int MUL_BITS = PRECISION + $clog2(RESOLUTION_X) + 1;

    localparam logic [PRECISION-1:0] RES_X_C = PRECISION'(RESOLUTION_X);
    localparam logic [PRECISION-1:0] RES_Y_C = PRECISION'(RESOLUTION_Y);

    typedef logic [PIXEL_BITS-1:0] pixel_t;
    typedef logic [ADDR_BITS-1:0]  addr_t;
    typedef logic [PRECISION-1:0]  coord_t;

    typedef struct packed {
        addr_t  addr;
        pixel_t pixel;
    } fb_entry_t;

    function automatic addr_t linear_addr(input coord_t x, input coord_t y);
        logic [MUL_BITS-1:0] full;
        full = MUL_BITS'(y) * MUL_BITS'(RESOLUTION_X) + MUL_BITS'(x);
        return full[ADDR_BITS-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter; a push into a full
// FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_din,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_dout,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  w_pop;
    logic                  w_push;

    assign o_full  = (r_level == (DEPTH_LOG2+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (DEPTH_LOG2+1)'(1);
                2'b01:   r_level <= r_level - (DEPTH_LOG2+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/fg_framebuffer_writer.sv
// Foreground capture write path: range check and address generation, FIFO
// buffering, and req/ack write requests toward the SRAM arbiter.
module fg_framebuffer_writer
    import fg_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     capture_valid,
    input  coord_t                   capture_x,
    input  coord_t                   capture_y,
    input  pixel_t                   capture_pixel,
    output logic                     wr_req,
    output addr_t                    wr_addr,
    output pixel_t                   wr_data,
    input  logic                     wr_ack,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level,
    output logic                     overflow,
    output logic [15:0]              dropped_count
);

    logic      r_s1_valid;
    fb_entry_t r_s1_entry;
    logic      r_overflow;
    logic [15:0] r_dropped;

    logic      w_in_range;
    logic      w_pop;
    logic      w_drop;
    logic      w_fifo_full;
    logic      w_fifo_empty;
    fb_entry_t w_head;

    assign w_in_range = capture_valid && (capture_x < RES_X_C) && (capture_y < RES_Y_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_entry <= '0;
        end else begin
            r_s1_valid       <= w_in_range;
            r_s1_entry.addr  <= linear_addr(capture_x, capture_y);
            r_s1_entry.pixel <= capture_pixel;
        end
    end

    sync_fifo #(
        .WIDTH      (ADDR_BITS + PIXEL_BITS),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_s1_valid),
        .i_din   (r_s1_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (fifo_level)
    );

    assign w_pop  = wr_req && wr_ack;
    assign w_drop = r_s1_valid && w_fifo_full && !w_pop;

    // Storage is not reset, so the head is masked to keep the bus at zero when idle.
    assign wr_req  = !w_fifo_empty;
    assign wr_addr = w_fifo_empty ? '0 : w_head.addr;
    assign wr_data = w_fifo_empty ? '0 : w_head.pixel;

    // A drop on the frame_start edge counts toward the new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else if (frame_start) begin
            r_overflow <= w_drop;
            r_dropped  <= w_drop ? 16'd1 : 16'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_dropped != 16'hFFFF) begin
                r_dropped <= r_dropped + 16'd1;
            end
        end
    end

    assign overflow      = r_overflow;
    assign dropped_count = r_dropped;

endmodule

// File: tb/tb_fg_framebuffer_writer.sv
// Self-checking bench for fg_framebuffer_writer: expected writes are queued as
// pixels are driven and matched against each accepted write request.
module tb_fg_framebuffer_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        capture_valid = 1'b0;
    logic [10:0] capture_x = '0;
    logic [10:0] capture_y = '0;
    logic [11:0] capture_pixel = '0;
    logic        wr_req;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ack = 1'b0;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [15:0] dropped_count;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    logic [30:0] sb[$];

    fg_framebuffer_writer dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .capture_valid (capture_valid),
        .capture_x     (capture_x),
        .capture_y     (capture_y),
        .capture_pixel (capture_pixel),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .dropped_count (dropped_count)
    );

    always #5 clk = ~clk;

    // Scoreboard: a request with ack visible mid-cycle is consumed on the next edge.
    always @(negedge clk) begin
        if (!rst && wr_req && wr_ack) begin
            logic [30:0] exp;
            checks++;
            n_writes++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected addr=%0d data=%h (no write expected)", wr_addr, wr_data);
            end else begin
                exp = sb.pop_front();
                if ({wr_addr, wr_data} !== exp) begin
                    errors++;
                    $display("FAIL write_order got addr=%0d data=%h expected addr=%0d data=%h",
                             wr_addr, wr_data, exp[30:12], exp[11:0]);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [30:0] exp_entry(input int x, input int y, input logic [11:0] p);
        logic [18:0] a;
        a = 19'(y * 800 + x);
        return {a, p};
    endfunction

    task automatic set_pix(input int x, input int y, input logic [11:0] p, input logic expect_write);
        capture_valid = 1'b1;
        capture_x     = 11'(x);
        capture_y     = 11'(y);
        capture_pixel = p;
        if (expect_write) sb.push_back(exp_entry(x, y, p));
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({wr_req, wr_addr, wr_data, fifo_level, overflow, dropped_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b addr=%0d data=%h lvl=%0d ovf=%b drop=%0d required all 0",
                     wr_req, wr_addr, wr_data, fifo_level, overflow, dropped_count);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (wr_req !== 1'b0 || fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL reset_release got req=%b lvl=%0d required 0 0", wr_req, fifo_level);
        end
    endtask

    task automatic test_single_pixel();
        int w0;
        w0 = n_writes;
        wr_ack = 1'b1;
        set_pix(5, 2, 12'hABC, 1'b1);
        tick();
        capture_valid = 1'b0;
        checks++;
        if (wr_req !== 1'b0) begin
            errors++;
            $display("FAIL single_latency_early got req=%b required 0", wr_req);
        end
        tick();
        checks++;
        if (wr_req !== 1'b1 || wr_addr !== 19'd1605 || wr_data !== 12'hABC) begin
            errors++;
            $display("FAIL single_req got req=%b addr=%0d data=%h required 1 1605 abc", wr_req, wr_addr, wr_data);
        end
        tick();
        checks++;
        if (wr_req !== 1'b0) begin
            errors++;
            $display("FAIL single_done got req=%b required 0", wr_req);
        end
        repeat (3) tick();
        checks++;
        if (n_writes - w0 != 1) begin
            errors++;
            $display("FAIL single_count got %0d writes required 1", n_writes - w0);
        end
    endtask

    task automatic test_out_of_range();
        int w0;
        w0 = n_writes;
        wr_ack = 1'b1;
        set_pix(800, 0, 12'h111, 1'b0);
        tick();
        set_pix(0, 600, 12'h222, 1'b0);
        tick();
        set_pix(799, 599, 12'h333, 1'b1);
        tick();
        capture_valid = 1'b0;
        checks++;
        if (exp_entry(799, 599, 12'h333) !== {19'd479999, 12'h333}) begin
            errors++;
            $display("FAIL range_model bench address model disagrees with 479999");
        end
        repeat (5) tick();
        checks++;
        if (n_writes - w0 != 1 || overflow !== 1'b0 || fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL range_result got writes=%0d ovf=%b lvl=%0d required 1 0 0",
                     n_writes - w0, overflow, fifo_level);
        end
    endtask

    task automatic drain(input int expected, input string name);
        int w0;
        w0 = n_writes;
        wr_ack = 1'b1;
        repeat (expected + 4) tick();
        wr_ack = 1'b0;
        checks++;
        if (n_writes - w0 != expected || fifo_level !== 5'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got writes=%0d lvl=%0d left=%0d required %0d 0 0",
                     name, n_writes - w0, fifo_level, sb.size(), expected);
        end
    endtask

    task automatic test_overflow();
        wr_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_pix(i, 10, 12'(12'h100 + i), i < 16);
            tick();
        end
        capture_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (fifo_level !== 5'd16 || overflow !== 1'b1 || dropped_count !== 16'd4 || wr_req !== 1'b1) begin
            errors++;
            $display("FAIL overflow_state got lvl=%0d ovf=%b drop=%0d req=%b required 16 1 4 1",
                     fifo_level, overflow, dropped_count, wr_req);
        end
        drain(16, "overflow");
    endtask

    task automatic test_full_push_pop();
        int w0;
        wr_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_pix(i, 20, 12'(12'h200 + i), 1'b1);
            tick();
        end
        capture_valid = 1'b0;
        tick();
        tick();
        w0 = n_writes;
        set_pix(16, 20, 12'h2F0, 1'b1);
        tick();
        capture_valid = 1'b0;
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        checks++;
        if (fifo_level !== 5'd16 || dropped_count !== 16'd4 || n_writes - w0 != 1) begin
            errors++;
            $display("FAIL full_pushpop got lvl=%0d drop=%0d writes=%0d required 16 4 1",
                     fifo_level, dropped_count, n_writes - w0);
        end
        drain(16, "full_pushpop");
    endtask

    task automatic test_frame_start_collision();
        wr_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_pix(i, 30, 12'(12'h300 + i), 1'b1);
            tick();
        end
        capture_valid = 1'b0;
        tick();
        tick();
        set_pix(16, 30, 12'h3F0, 1'b0);
        tick();
        capture_valid = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++;
        if (overflow !== 1'b1 || dropped_count !== 16'd1 || fifo_level !== 5'd16) begin
            errors++;
            $display("FAIL fs_collision got ovf=%b drop=%0d lvl=%0d required 1 1 16",
                     overflow, dropped_count, fifo_level);
        end
        drain(16, "fs_collision");
    endtask

    task automatic test_frame_start_pending();
        wr_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_pix(100 + i, 40, 12'(12'h400 + i), 1'b1);
            tick();
        end
        capture_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (fifo_level !== 5'd5 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL fs_pending_pre got lvl=%0d ovf=%b required 5 1", fifo_level, overflow);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++;
        if (overflow !== 1'b0 || dropped_count !== 16'd0 || fifo_level !== 5'd5) begin
            errors++;
            $display("FAIL fs_pending_clear got ovf=%b drop=%0d lvl=%0d required 0 0 5",
                     overflow, dropped_count, fifo_level);
        end
        drain(5, "fs_pending");
    endtask

    task automatic test_async_reset();
        int w0;
        wr_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_pix(200 + i, 50, 12'(12'h500 + i), 1'b1);
            tick();
        end
        capture_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (fifo_level !== 5'd3 || wr_req !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got lvl=%0d req=%b required 3 1", fifo_level, wr_req);
        end
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        checks++;
        if (wr_req !== 1'b0 || fifo_level !== 5'd0 || wr_addr !== 19'd0 || wr_data !== 12'd0) begin
            errors++;
            $display("FAIL areset_immediate got req=%b lvl=%0d addr=%0d data=%h required 0 0 0 0",
                     wr_req, fifo_level, wr_addr, wr_data);
        end
        tick();
        rst = 1'b0;
        w0 = n_writes;
        wr_ack = 1'b1;
        repeat (10) tick();
        wr_ack = 1'b0;
        checks++;
        if (n_writes - w0 != 0 || wr_req !== 1'b0) begin
            errors++;
            $display("FAIL areset_stale got writes=%0d req=%b required 0 0", n_writes - w0, wr_req);
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_out_of_range();
        test_overflow();
        test_full_push_pop();
        test_frame_start_collision();
        test_frame_start_pending();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
